fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
- Read-side controller for the single-port-RAM FIFO; the consumer end that pops words and presents them downstream.
- Drives the FIFO read strobe and read port select, absorbs the FIFO's 1-cycle registered read latency, and outputs words on a valid/ready stream.
- Two-entry output buffer gives one word per cycle when the sink is always ready; enable/flush FSM allows clean stop.

Parameters:
- BIT_D, 32, data word width
- CNT_W, 3, width of FIFO occupancy input
- NUM_REG, 6, FIFO depth (max occupancy)

Ports:
- clk_i  input  1  clock, rising edge
- arst_i  input  1  reset, asynchronous, active-high
- en_i  input  1  drain enable
- fifo_cnt_i  input  CNT_W  FIFO occupancy (registered in FIFO)
- fifo_empty_i  input  1  FIFO empty flag
- fifo_data_i  input  BIT_D  FIFO read data, valid 1 cycle after rd_o
- fifo_rd_o  output  1  FIFO pop strobe
- fifo_sel_rd_o  output  1  port select to FIFO: 1 = read, 0 = write side owns port
- m_data_o  output  BIT_D  stream data
- m_valid_o  output  1  stream valid
- m_ready_i  input  1  stream ready
- idle_o  output  1  FSM in IDLE and buffer empty

Behaviour:
- Reset (async, arst_i=1): all outputs 0 except idle_o=1; FSM=IDLE, buffer empty, in-flight flag 0, buffer pointers 0.
- State machine (2-bit): IDLE, RUN, FLUSH.
  - IDLE -> RUN when en_i=1.
  - RUN -> FLUSH when en_i=0.
  - FLUSH -> IDLE when in-flight=0 and buffer empty.
  - FLUSH -> RUN when en_i=1 again.
- Read issue, RUN only: fifo_rd_o=1 when fifo_empty_i=0 and (buffer occupancy + in-flight) < 2, counting a same-cycle downstream pop as freeing a slot.
- fifo_sel_rd_o=1 during the issue cycle and the following capture cycle; otherwise 0.
- In-flight flag is set the cycle after fifo_rd_o; fifo_data_i is captured into the buffer on that cycle.
- Latency: FIFO word to m_valid_o = 2 cycles after fifo_rd_o (1 RAM + 1 buffer register).
- Back-to-back reads are legal: fifo_cnt_i/fifo_empty_i are updated by the FIFO at the same edge as the pop, so they are current next cycle.
- Buffer: 2-entry circular, 1-bit rd/wr pointers, 2-bit count.
  - Push and pop in the same cycle leaves the count unchanged.
  - Push when count==2 never occurs by construction; assertion required.
- Stream: m_valid_o = buffer not empty; m_data_o = head entry, registered.
  - m_data_o and m_valid_o hold stable while m_valid_o=1 and m_ready_i=0.
  - Pop on m_valid_o & m_ready_i.
- FLUSH: no new reads; the in-flight word is captured and the buffer drains normally.
- Mid-operation reset: buffered and in-flight words are discarded; no fifo_rd_o on the cycle reset deasserts.
- fifo_empty_i=1 in RUN: no read issued; stay in RUN.

Optional Feature:
- Macro: FIFO_RD_LAST_EN.
- With macro defined:
  - Adds output m_last_o (1 bit), stored per buffer entry.
  - Set for a word read when fifo_cnt_i==1 at the issue cycle.
  - Marks a word that emptied the FIFO; stable under backpressure; reset 0.
- Without the macro: the port does not exist and there is no per-entry storage.

Decomposition:
- Package fifo_rd_pkg: state typedef/localparams (ST_IDLE=0, ST_RUN=1, ST_FLUSH=2) and SKID_DEPTH=2.
- One sub-module, fifo_rd_skid: the 2-entry buffer with push, data_in, pop, data_out, count.
- The top level holds the FSM and issue logic.

Test Plan:
- Reset, then FIFO preloaded with 0xA0..0xA5 (cnt=6), en_i=1, m_ready_i=1:
  - six consecutive fifo_rd_o pulses;
  - m_data_o 0xA0..0xA5 on six consecutive cycles, first two cycles after the first fifo_rd_o.
- Same preload, m_ready_i held 0:
  - exactly two reads issued;
  - m_data_o=0xA0 held stable;
  - releasing m_ready_i resumes in order with no loss or duplicate.
- Empty FIFO, en_i=1:
  - no fifo_rd_o, m_valid_o=0, idle_o=0;
  - one word 0x55 written: read issued next cycle, 0x55 appears 2 cycles later.
- en_i dropped the cycle after a read is issued:
  - the in-flight word is still delivered;
  - FSM passes FLUSH and reaches IDLE; idle_o=1 only once the buffer is empty.
- arst_i pulsed mid-stream with 2 words buffered:
  - m_valid_o=0 and fifo_rd_o=0 immediately, with no clock edge needed;
  - idle_o=1.
- FIFO_RD_LAST_EN defined, 3 words preloaded:
  - m_last_o=1 only with the third word;
  - with a concurrent write keeping cnt>1, m_last_o stays 0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side controller.
package fifo_rd_pkg;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = 2;
  localparam int unsigned OCC_W      = SKID_CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Room for one more word once buffered + in-flight words, less a same-cycle pop, are counted.
  function automatic logic skid_room(input logic [SKID_CNT_W-1:0] cnt,
                                     input logic                  inflight,
                                     input logic                  pop);
    logic [OCC_W-1:0] occ;
    occ = {1'b0, cnt} + OCC_W'(inflight) - OCC_W'(pop);
    return occ < OCC_W'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read port plus downstream valid/ready stream seen by fifo_rd_ctrl.
// FIFO_RD_LAST_EN adds the m_last_o stream flag.
interface fifo_rd_ctrl_if #(
  parameter int unsigned BIT_D = 32,
  parameter int unsigned CNT_W = 3
);
  logic [CNT_W-1:0] fifo_cnt_i;
  logic             fifo_empty_i;
  logic [BIT_D-1:0] fifo_data_i;
  logic             fifo_rd_o;
  logic             fifo_sel_rd_o;
  logic [BIT_D-1:0] m_data_o;
  logic             m_valid_o;
  logic             m_ready_i;
`ifdef FIFO_RD_LAST_EN
  logic             m_last_o;

  modport master (
    input  fifo_cnt_i, fifo_empty_i, fifo_data_i, m_ready_i,
    output fifo_rd_o, fifo_sel_rd_o, m_data_o, m_valid_o, m_last_o
  );

  modport slave (
    output fifo_cnt_i, fifo_empty_i, fifo_data_i, m_ready_i,
    input  fifo_rd_o, fifo_sel_rd_o, m_data_o, m_valid_o, m_last_o
  );
`else
  modport master (
    input  fifo_cnt_i, fifo_empty_i, fifo_data_i, m_ready_i,
    output fifo_rd_o, fifo_sel_rd_o, m_data_o, m_valid_o
  );

  modport slave (
    output fifo_cnt_i, fifo_empty_i, fifo_data_i, m_ready_i,
    input  fifo_rd_o, fifo_sel_rd_o, m_data_o, m_valid_o
  );
`endif
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry circular output buffer with a registered head word and valid.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  push_i,
  input  logic [DW-1:0]         data_i,
  input  logic                  pop_i,
  output logic [DW-1:0]         data_o,
  output logic                  valid_o,
  output logic [SKID_CNT_W-1:0] count_o
);

  logic [DW-1:0]         mem_q [SKID_DEPTH];
  logic [DW-1:0]         mem_d [SKID_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic                  rd_ptr_d;
  logic [SKID_CNT_W-1:0] count_q;
  logic [SKID_CNT_W-1:0] count_d;
  logic [DW-1:0]         data_q;
  logic                  valid_q;

  // Next-state view so the head register can be loaded from post-update contents.
  always_comb begin
    mem_d = mem_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
    end
    rd_ptr_d = rd_ptr_q ^ pop_i;
    count_d  = count_q + SKID_CNT_W'(push_i) - SKID_CNT_W'(pop_i);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_q ^ push_i;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      if (count_d != '0) begin
        data_q <= mem_d[rd_ptr_d];
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (arst_i)
    push_i |-> (count_q < SKID_CNT_W'(SKID_DEPTH)));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (arst_i)
    pop_i |-> (count_q != '0));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the single-port-RAM FIFO: issues pops, absorbs RAM latency, streams out.
// Optional FIFO_RD_LAST_EN adds m_last_o marking the word that emptied the FIFO.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int unsigned BIT_D   = 32,
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned NUM_REG = 6
) (
  input  logic           clk_i,
  input  logic           arst_i,
  input  logic           en_i,
  fifo_rd_ctrl_if.master rd_if,
  output logic           idle_o
);

`ifdef FIFO_RD_LAST_EN
  localparam int unsigned SKID_W = BIT_D + 1;
`else
  localparam int unsigned SKID_W = BIT_D;
`endif

  state_t                state_q;
  logic                  inflight_q;
  logic                  issue;
  logic                  skid_pop;
  logic                  skid_valid;
  logic [SKID_CNT_W-1:0] skid_cnt;
  logic [SKID_W-1:0]     skid_din;
  logic [SKID_W-1:0]     skid_dout;

  // Issue decision must see this cycle's FIFO flags, so the pop strobe is decoded, not registered.
  assign skid_pop = skid_valid & rd_if.m_ready_i;
  assign issue    = (state_q == ST_RUN) && !rd_if.fifo_empty_i
                    && skid_room(skid_cnt, inflight_q, skid_pop);

  assign rd_if.fifo_rd_o     = issue;
  assign rd_if.fifo_sel_rd_o = issue | inflight_q;
  assign rd_if.m_valid_o     = skid_valid;
  assign idle_o              = (state_q == ST_IDLE) && !skid_valid;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      unique case (state_q)
        ST_IDLE: begin
          if (en_i) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!en_i) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (en_i) begin
            state_q <= ST_RUN;
          end else if (!inflight_q && !skid_valid) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_LAST_EN
  logic last_q;

  // Word popped while it was the only one left in the FIFO.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      last_q <= 1'b0;
    end else begin
      last_q <= issue && (rd_if.fifo_cnt_i == CNT_W'(1));
    end
  end

  assign skid_din       = {last_q, rd_if.fifo_data_i};
  assign rd_if.m_data_o = skid_dout[BIT_D-1:0];
  assign rd_if.m_last_o = skid_dout[BIT_D] & skid_valid;
`else
  assign skid_din       = rd_if.fifo_data_i;
  assign rd_if.m_data_o = skid_dout;
`endif

  fifo_rd_skid #(
    .DW (SKID_W)
  ) u_skid (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .push_i  (inflight_q),
    .data_i  (skid_din),
    .pop_i   (skid_pop),
    .data_o  (skid_dout),
    .valid_o (skid_valid),
    .count_o (skid_cnt)
  );

  a_cnt_range: assert property (@(posedge clk_i) disable iff (arst_i)
    rd_if.fifo_cnt_i <= CNT_W'(NUM_REG));

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a small behavioural FIFO model on the read port.
`timescale 1ns/1ps
module tb_fifo_rd_ctrl;

  localparam int unsigned BIT_D   = 32;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned NUM_REG = 6;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  logic en   = 1'b0;
  logic idle;

  int total = 0;
  int bad   = 0;
  int uf    = 0;

  logic             wr_req  = 1'b0;
  logic             clr_req = 1'b0;
  logic [BIT_D-1:0] wr_data = '0;
  logic [BIT_D-1:0] fq [$];

  fifo_rd_ctrl_if #(.BIT_D(BIT_D), .CNT_W(CNT_W)) rd_if ();

  fifo_rd_ctrl #(
    .BIT_D   (BIT_D),
    .CNT_W   (CNT_W),
    .NUM_REG (NUM_REG)
  ) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .en_i   (en),
    .rd_if  (rd_if),
    .idle_o (idle)
  );

  always #5 clk = ~clk;

  // FIFO model: pop and write take effect on the edge, flags are current the next cycle.
  always @(posedge clk) begin
    if (clr_req) fq.delete();
    if (rd_if.fifo_rd_o) begin
      if (fq.size() != 0) rd_if.fifo_data_i <= fq.pop_front();
      else uf++;
    end
    if (wr_req) fq.push_back(wr_data);
    rd_if.fifo_cnt_i   <= CNT_W'(fq.size());
    rd_if.fifo_empty_i <= (fq.size() == 0);
  end

  task automatic chk(input string tag, input logic [BIT_D-1:0] got, input logic [BIT_D-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic preload(input logic [BIT_D-1:0] base, input int n);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_req  = 1'b1;
      wr_data = base + BIT_D'(i);
      step();
    end
    wr_req = 1'b0;
    step();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!idle && n < 50) begin
      step();
      n++;
    end
    chk(tag, BIT_D'(idle), BIT_D'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrd;
    int got;
    int n;
    rd_if.m_ready_i = 1'b0;
    step();
    step();
    chk("rst_valid", BIT_D'(rd_if.m_valid_o), BIT_D'(0));
    chk("rst_rd", BIT_D'(rd_if.fifo_rd_o), BIT_D'(0));
    chk("rst_sel", BIT_D'(rd_if.fifo_sel_rd_o), BIT_D'(0));
    chk("rst_data", rd_if.m_data_o, BIT_D'(0));
    chk("rst_idle", BIT_D'(idle), BIT_D'(1));
    arst = 1'b0;
    step();

    // Full-rate drain of six words with sink always ready.
    preload(32'hA0, 6);
    rd_if.m_ready_i = 1'b1;
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("t1_rd", BIT_D'(rd_if.fifo_rd_o), BIT_D'(c >= 1 && c <= 6));
      chk("t1_valid", BIT_D'(rd_if.m_valid_o), BIT_D'(c >= 3 && c <= 8));
      if (c >= 3 && c <= 8) chk("t1_data", rd_if.m_data_o, BIT_D'(32'hA0 + c - 3));
      step();
    end
    en = 1'b0;
    wait_idle("t1_idle");

    // Sink stalled: only two reads, head word held, then in-order resume.
    preload(32'hA0, 6);
    rd_if.m_ready_i = 1'b0;
    en = 1'b1;
    nrd = 0;
    for (int c = 0; c < 8; c++) begin
      if (rd_if.fifo_rd_o) nrd++;
      chk("t2_rd", BIT_D'(rd_if.fifo_rd_o), BIT_D'(c == 1 || c == 2));
      if (c >= 3) begin
        chk("t2_hold_valid", BIT_D'(rd_if.m_valid_o), BIT_D'(1));
        chk("t2_hold_data", rd_if.m_data_o, BIT_D'(32'hA0));
      end
      step();
    end
    chk("t2_nrd", BIT_D'(nrd), BIT_D'(2));
    rd_if.m_ready_i = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rd_if.m_valid_o && rd_if.m_ready_i) begin
        chk("t2_order", rd_if.m_data_o, BIT_D'(32'hA0 + got));
        got++;
      end
      step();
    end
    chk("t2_count", BIT_D'(got), BIT_D'(6));
    en = 1'b0;
    wait_idle("t2_idle");

    // Empty FIFO while enabled, then a single late word.
    preload(32'h0, 0);
    en = 1'b1;
    step();
    for (int c = 0; c < 2; c++) begin
      chk("t3_no_rd", BIT_D'(rd_if.fifo_rd_o), BIT_D'(0));
      chk("t3_no_valid", BIT_D'(rd_if.m_valid_o), BIT_D'(0));
      chk("t3_not_idle", BIT_D'(idle), BIT_D'(0));
      step();
    end
    wr_req  = 1'b1;
    wr_data = 32'h55;
    step();
    wr_req = 1'b0;
    chk("t3_rd_issue", BIT_D'(rd_if.fifo_rd_o), BIT_D'(1));
    chk("t3_sel_issue", BIT_D'(rd_if.fifo_sel_rd_o), BIT_D'(1));
    step();
    chk("t3_rd_once", BIT_D'(rd_if.fifo_rd_o), BIT_D'(0));
    chk("t3_sel_capture", BIT_D'(rd_if.fifo_sel_rd_o), BIT_D'(1));
    chk("t3_valid_early", BIT_D'(rd_if.m_valid_o), BIT_D'(0));
    step();
    chk("t3_valid", BIT_D'(rd_if.m_valid_o), BIT_D'(1));
    chk("t3_data", rd_if.m_data_o, BIT_D'(32'h55));
    chk("t3_sel_off", BIT_D'(rd_if.fifo_sel_rd_o), BIT_D'(0));
    step();

    // Enable dropped with a word in flight: delivered through FLUSH before IDLE.
    wr_req  = 1'b1;
    wr_data = 32'h77;
    step();
    wr_req = 1'b0;
    chk("t4_rd", BIT_D'(rd_if.fifo_rd_o), BIT_D'(1));
    step();
    en = 1'b0;
    chk("t4_inflight_valid", BIT_D'(rd_if.m_valid_o), BIT_D'(0));
    step();
    chk("t4_valid", BIT_D'(rd_if.m_valid_o), BIT_D'(1));
    chk("t4_data", rd_if.m_data_o, BIT_D'(32'h77));
    chk("t4_idle_busy", BIT_D'(idle), BIT_D'(0));
    step();
    chk("t4_flush_idle", BIT_D'(idle), BIT_D'(0));
    chk("t4_drained", BIT_D'(rd_if.m_valid_o), BIT_D'(0));
    step();
    chk("t4_idle", BIT_D'(idle), BIT_D'(1));

    // Asynchronous reset with two words buffered and a read about to issue.
    preload(32'hA0, 6);
    rd_if.m_ready_i = 1'b0;
    en = 1'b1;
    repeat (4) step();
    chk("t5_full", BIT_D'(rd_if.m_valid_o), BIT_D'(1));
    rd_if.m_ready_i = 1'b1;
    #1;
    chk("t5_rd_pre", BIT_D'(rd_if.fifo_rd_o), BIT_D'(1));
    arst = 1'b1;
    #1;
    chk("t5_valid", BIT_D'(rd_if.m_valid_o), BIT_D'(0));
    chk("t5_rd", BIT_D'(rd_if.fifo_rd_o), BIT_D'(0));
    chk("t5_idle", BIT_D'(idle), BIT_D'(1));
    step();
    arst = 1'b0;
    #1;
    chk("t5_rd_release", BIT_D'(rd_if.fifo_rd_o), BIT_D'(0));
    n = 0;
    while (!rd_if.m_valid_o && n < 10) begin
      step();
      n++;
    end
    chk("t5_next_word", rd_if.m_data_o, BIT_D'(32'hA2));
    en = 1'b0;
    wait_idle("t5_idle_end");

`ifdef FIFO_RD_LAST_EN
    // Last flag on the word that emptied the FIFO.
    preload(32'hB0, 3);
    rd_if.m_ready_i = 1'b1;
    en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      chk("t6_last", BIT_D'(rd_if.m_last_o), BIT_D'(c == 5));
      if (c >= 3 && c <= 5) chk("t6_data", rd_if.m_data_o, BIT_D'(32'hB0 + c - 3));
      step();
    end
    en = 1'b0;
    wait_idle("t6_idle");

    // A write concurrent with a pop keeps the count above one, deferring the flag.
    preload(32'hC0, 2);
    en = 1'b1;
    step();
    wr_req  = 1'b1;
    wr_data = 32'hC2;
    step();
    wr_req = 1'b0;
    step();
    for (int c = 3; c < 6; c++) begin
      chk("t7_data", rd_if.m_data_o, BIT_D'(32'hC0 + c - 3));
      chk("t7_last", BIT_D'(rd_if.m_last_o), BIT_D'(c == 5));
      step();
    end
    en = 1'b0;
    wait_idle("t7_idle");
`endif

    chk("fifo_underflow", BIT_D'(uf), BIT_D'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
